seq_add_engine: RTL
===================

SEQ_ADD_ENGINE -- requirements
Module: seq_add_engine

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; legal range 2..32.
REQ-002 Parameter NUM_OPS, default 2: operands per transaction; legal range 2..16; internal counter width is $clog2(NUM_OPS)+1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 p  input  WIDTH  operand value, sampled at the same edge as p_seq.
REQ-006 p_seq  input  2  operand tag: 0 none, 1 first operand, 2 subsequent operand, 3 abort.
REQ-007 op_mode  input  1  0 add, 1 subtract; sampled only with p_seq==1.
REQ-008 res_ready  input  1  consumer accepts the result.
REQ-009 res_valid  output  1  result available; held until accepted.
REQ-010 s  output  WIDTH  result value.
REQ-011 res_ovf  output  1  sticky carry (add) or borrow (sub) flag for the transaction.
REQ-012 busy  output  1  high in ACCUM and DONE.
REQ-013 seq_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCUM and DONE. All outputs SHALL be registered.
REQ-015 In IDLE with p_seq==1: acc<=p, cnt<=1, mode<=op_mode, ovf<=0, next state ACCUM.
REQ-016 In IDLE with p_seq==2: seq_err SHALL pulse, and the state SHALL remain IDLE.
REQ-017 In IDLE with p_seq==3 or 0: no action.
REQ-018 In ACCUM with p_seq==2, the block SHALL update:
- acc<=acc+p (mode 0) or acc-p (mode 1), modulo 2^WIDTH;
- ovf<=ovf | carry-out (add) or ovf | borrow (sub);
- cnt<=cnt+1.
REQ-019 In ACCUM, when the p_seq==2 operand makes cnt reach NUM_OPS, the next state SHALL be DONE; on that same edge s<=new acc, res_ovf<=new ovf and res_valid<=1. Latency: res_valid is visible one cycle after the edge that samples the final operand.
REQ-020 In ACCUM with p_seq==1 (restart): seq_err SHALL pulse and the block SHALL reload as in REQ-015; the state SHALL remain ACCUM.
REQ-021 In ACCUM with p_seq==3 (abort): the next state SHALL be IDLE, no result SHALL be produced, and seq_err SHALL stay 0.
REQ-022 In ACCUM with p_seq==0: all registers SHALL hold, with no timeout.
REQ-023 In DONE, res_valid, s and res_ovf SHALL hold stable until a clock edge with res_ready==1.
- On that edge: res_valid<=0, s<=0, res_ovf<=0, next state IDLE.
REQ-024 In DONE, a p_seq value other than 0 SHALL be ignored and SHALL pulse seq_err; this includes a p_seq==1 coinciding with res_ready, which is not captured.
REQ-025 Whenever res_valid==0, s and res_ovf SHALL be 0.
REQ-026 An unreachable state encoding SHALL return to IDLE on the next edge, with outputs cleared.
REQ-027 busy SHALL be the registered decode of the state: 1 in ACCUM or DONE, 0 in IDLE.

Reset
REQ-028 On a rising clk edge with rst_n==0, the block SHALL reset as follows:
- state<=IDLE;
- acc, cnt, mode and ovf <=0;
- res_valid, s, res_ovf, busy and seq_err <=0.
REQ-029 Reset SHALL take priority over every other input in any state, including mid-ACCUM and DONE, and the partial transaction SHALL be discarded.
REQ-030 Changes of rst_n between clock edges SHALL have no effect on the state or outputs.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- WIDTH=4, NUM_OPS=2, res_ready=1: p_seq=1,p=2 then p_seq=2,p=3 -> s=5, res_valid high for 1 cycle, res_ovf=0.
- Same configuration: 9 then 8, mode 0 -> s=1, res_ovf=1.
- NUM_OPS=4, mode 1: operands 10, 3, 2, 1 -> s=4, res_ovf=0; operands 1, 2, 0, 0 -> s=15, res_ovf=1.
- res_ready=0 for 5 cycles after the result -> res_valid, s and res_ovf stable for all 5; raising res_ready -> res_valid=0 next cycle, busy=0.
- Sequence violations:
  - p_seq=2 in IDLE -> seq_err pulse, no state change.
  - p_seq=1,p=4 then p_seq=1,p=7 then p_seq=2,p=1 -> seq_err pulse, s=8.
- Abort and reset:
  - p_seq=3 mid-ACCUM -> IDLE, no res_valid.
  - rst_n=0 for 1 edge mid-ACCUM -> all outputs 0; the next clean transaction of 2+3 gives s=5.

Source files
------------

// File: rtl/seq_add_engine.sv
// Sequential add/subtract engine: accumulates a tagged operand stream of NUM_OPS
// values and presents the result with a sticky carry/borrow flag.
module seq_add_engine #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] p,
  input  logic [1:0]       p_seq,
  input  logic             op_mode,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] s,
  output logic             res_ovf,
  output logic             busy,
  output logic             seq_err,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(NUM_OPS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_OPS);

  localparam logic [1:0] SEQ_NONE  = 2'd0;
  localparam logic [1:0] SEQ_FIRST = 2'd1;
  localparam logic [1:0] SEQ_NEXT  = 2'd2;
  localparam logic [1:0] SEQ_ABORT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             mode;
  logic             ovf;

  logic [WIDTH:0]   step;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_next;
  logic [CW-1:0]    cnt_next;

  assign state_dbg = state;

  // The extra top bit of step is the carry-out on add and the borrow on subtract.
  always_comb begin
    step = '0;
    if (mode) step = {1'b0, acc} - {1'b0, p};
    else      step = {1'b0, acc} + {1'b0, p};
    acc_next = step[WIDTH-1:0];
    ovf_next = ovf | step[WIDTH];
    cnt_next = cnt + CW'(1);
  end

  // Handshake: a result transfers on a rising edge where res_valid and res_ready
  // are both high; while res_valid is high and res_ready low, s and res_ovf hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      mode      <= 1'b0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
      s         <= '0;
      res_ovf   <= 1'b0;
      busy      <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      case (state)
        IDLE: begin
          if (p_seq == SEQ_FIRST) begin
            acc   <= p;
            cnt   <= CW'(1);
            mode  <= op_mode;
            ovf   <= 1'b0;
            state <= ACCUM;
            busy  <= 1'b1;
          end else if (p_seq == SEQ_NEXT) begin
            seq_err <= 1'b1;
          end
        end
        ACCUM: begin
          case (p_seq)
            SEQ_FIRST: begin
              seq_err <= 1'b1;
              acc     <= p;
              cnt     <= CW'(1);
              mode    <= op_mode;
              ovf     <= 1'b0;
            end
            SEQ_NEXT: begin
              acc <= acc_next;
              ovf <= ovf_next;
              cnt <= cnt_next;
              if (cnt_next == LAST_CNT) begin
                state     <= DONE;
                s         <= acc_next;
                res_ovf   <= ovf_next;
                res_valid <= 1'b1;
              end
            end
            SEQ_ABORT: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
            default: ;
          endcase
        end
        DONE: begin
          if (p_seq != SEQ_NONE) seq_err <= 1'b1;
          if (res_ready) begin
            res_valid <= 1'b0;
            s         <= '0;
            res_ovf   <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          s         <= '0;
          res_ovf   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
